// File: rtl/ft601_pkg.sv
// Shared types and widths for the FT601 245-sync FIFO controller.
package ft601_pkg;

  localparam int WORD_W  = 32;
  localparam int BE_W    = 4;
  localparam int ENTRY_W = WORD_W + BE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_OE = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_TURN  = 3'd4
  } ft601_state_e;

  // Burst counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ft601_ctrl_if.sv
// Chip-side bus plus rx/tx user streams of the FT601 controller.
interface ft601_ctrl_if;
  import ft601_pkg::*;

  logic              rxf_n;
  logic              txe_n;
  logic              oe_n;
  logic              rd_n;
  logic              wr_n;
  logic              siwu_n;
  logic              bus_oe;
  logic [WORD_W-1:0] data_in;
  logic [BE_W-1:0]   be_in;
  logic [WORD_W-1:0] data_out;
  logic [BE_W-1:0]   be_out;

  logic [WORD_W-1:0] rx_data;
  logic [BE_W-1:0]   rx_be;
  logic              rx_valid;
  logic              rx_ready;

  logic [WORD_W-1:0] tx_data;
  logic [BE_W-1:0]   tx_be;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  rxf_n, txe_n, data_in, be_in, rx_ready, tx_data, tx_be, tx_valid,
    output oe_n, rd_n, wr_n, siwu_n, bus_oe, data_out, be_out,
           rx_data, rx_be, rx_valid, tx_ready
  );

  modport slave (
    output rxf_n, txe_n, data_in, be_in, rx_ready, tx_data, tx_be, tx_valid,
    input  oe_n, rd_n, wr_n, siwu_n, bus_oe, data_out, be_out,
           rx_data, rx_be, rx_valid, tx_ready
  );

endinterface

// File: rtl/ft601_skid.sv
// Receive skid buffer: synchronous FIFO of {be, data} entries with occupancy.
module ft601_skid
  import ft601_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = AW + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_wr_en,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic               i_rd_ready,
  output logic [ENTRY_W-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic [OW-1:0]      o_occ
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [OW-1:0]      r_occ;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_full     = (r_occ == OW'(DEPTH));
  assign w_push     = i_wr_en && !w_full;
  assign o_rd_valid = (r_occ != '0);
  assign w_pop      = o_rd_valid && i_rd_ready;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_occ      = r_occ;

  // Storage array, written on push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/ft601_ctrl.sv
// FT601 245-sync FIFO master with alternating RD/WR burst arbitration.
// Optional FT601_CTRL_STATS_EN adds rx_words/tx_words transfer counters.
module ft601_ctrl
  import ft601_pkg::*;
#(
  parameter int MAX_BURST  = 64,
  parameter int SKID_DEPTH = 4
) (
  input logic          clk,
  input logic          reset_n,
  ft601_ctrl_if.master bus
`ifdef FT601_CTRL_STATS_EN
  ,
  output logic [31:0]  rx_words,
  output logic [31:0]  tx_words
`endif
);

  localparam int              OCC_W       = $clog2(SKID_DEPTH) + 1;
  localparam logic [7:0]      C_MAX_BURST = 8'(MAX_BURST);
  localparam logic [OCC_W-1:0] C_RD_HIGH  = OCC_W'(SKID_DEPTH - 2);
  localparam logic [OCC_W-1:0] C_RD_ENTRY = OCC_W'(1);

  ft601_state_e       r_state;
  ft601_state_e       w_state_nxt;
  logic               r_oe_n;
  logic               r_rd_n;
  logic               r_bus_oe;
  logic               r_rd_pri;
  logic [7:0]         r_burst;
  logic [7:0]         w_burst_inc;
  logic               w_burst_done;
  logic               w_burst_clr;
  logic               w_oe_n_nxt;
  logic               w_rd_n_nxt;
  logic               w_bus_oe_nxt;
  logic               w_rd_fire;
  logic               w_wr_fire;
  logic               w_rd_req;
  logic               w_wr_req;
  logic [OCC_W-1:0]   w_occ;
  logic [ENTRY_W-1:0] w_skid_data;
  logic               w_skid_valid;

  ft601_skid #(.DEPTH(SKID_DEPTH)) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_wr_en    (w_rd_fire),
    .i_wr_data  ({bus.be_in, bus.data_in}),
    .i_rd_ready (bus.rx_ready),
    .o_rd_data  (w_skid_data),
    .o_rd_valid (w_skid_valid),
    .o_occ      (w_occ)
  );

  // A word is taken from the chip on every edge where the registered rd_n is low.
  assign w_rd_fire    = !r_rd_n && !bus.rxf_n;
  assign w_rd_req     = !bus.rxf_n && (w_occ <= C_RD_ENTRY);
  assign w_wr_req     = bus.tx_valid && !bus.txe_n;
  assign w_burst_inc  = sat_inc8(r_burst);
  assign w_burst_done = (w_burst_inc >= C_MAX_BURST);
  assign w_burst_clr  = (r_state == ST_IDLE) &&
                        ((w_state_nxt == ST_RD_OE) || (w_state_nxt == ST_WR));

  assign bus.rx_data  = w_skid_data[WORD_W-1:0];
  assign bus.rx_be    = w_skid_data[ENTRY_W-1:WORD_W];
  assign bus.rx_valid = w_skid_valid;
  assign bus.oe_n     = r_oe_n;
  assign bus.rd_n     = r_rd_n;
  assign bus.bus_oe   = r_bus_oe;
  assign bus.wr_n     = !w_wr_fire;
  assign bus.tx_ready = w_wr_fire;
  assign bus.data_out = bus.tx_data;
  assign bus.be_out   = bus.tx_be;
  assign bus.siwu_n   = 1'b1;

  // State register, registered strobes, burst counter and arbitration priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_oe_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_bus_oe <= 1'b0;
      r_rd_pri <= 1'b1;
      r_burst  <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_oe_n   <= w_oe_n_nxt;
      r_rd_n   <= w_rd_n_nxt;
      r_bus_oe <= w_bus_oe_nxt;
      if (w_burst_clr) begin
        r_burst <= 8'd0;
      end else if (w_rd_fire || w_wr_fire) begin
        r_burst <= w_burst_inc;
      end else begin
        r_burst <= r_burst;
      end
      // The direction that just finished loses the next tie.
      if ((r_state == ST_RD) && (w_state_nxt == ST_TURN)) begin
        r_rd_pri <= 1'b0;
      end else if ((r_state == ST_WR) && (w_state_nxt == ST_TURN)) begin
        r_rd_pri <= 1'b1;
      end else begin
        r_rd_pri <= r_rd_pri;
      end
    end
  end

  // Next-state decision.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_req && (!w_wr_req || r_rd_pri)) begin
          w_state_nxt = ST_RD_OE;
        end else if (w_wr_req) begin
          w_state_nxt = ST_WR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_OE: w_state_nxt = ST_RD;
      ST_RD: begin
        // Exiting on a high-water skid still keeps this edge's word (room for it exists).
        if (bus.rxf_n || (w_rd_fire && w_burst_done) || (w_occ >= C_RD_HIGH)) begin
          w_state_nxt = ST_TURN;
        end else begin
          w_state_nxt = ST_RD;
        end
      end
      ST_WR: begin
        if (!w_wr_fire || w_burst_done) begin
          w_state_nxt = ST_TURN;
        end else begin
          w_state_nxt = ST_WR;
        end
      end
      ST_TURN: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state, plus the combinational write strobe.
  always_comb begin
    w_oe_n_nxt   = 1'b1;
    w_rd_n_nxt   = 1'b1;
    w_bus_oe_nxt = 1'b0;
    w_wr_fire    = (r_state == ST_WR) && bus.tx_valid && !bus.txe_n;
    case (w_state_nxt)
      ST_RD_OE: w_oe_n_nxt = 1'b0;
      ST_RD: begin
        w_oe_n_nxt = 1'b0;
        w_rd_n_nxt = 1'b0;
      end
      ST_WR:    w_bus_oe_nxt = 1'b1;
      default: begin
        w_oe_n_nxt   = 1'b1;
        w_rd_n_nxt   = 1'b1;
        w_bus_oe_nxt = 1'b0;
      end
    endcase
  end

`ifdef FT601_CTRL_STATS_EN
  logic [31:0] r_rx_words;
  logic [31:0] r_tx_words;

  // Wrapping chip-side transfer counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_words <= 32'd0;
      r_tx_words <= 32'd0;
    end else begin
      if (w_rd_fire) r_rx_words <= r_rx_words + 32'd1;
      if (w_wr_fire) r_tx_words <= r_tx_words + 32'd1;
    end
  end

  assign rx_words = r_rx_words;
  assign tx_words = r_tx_words;
`endif

endmodule

// File: tb/tb_ft601_ctrl.sv
// Directed bench for ft601_ctrl: chip/user models with rx and tx scoreboards.
module tb_ft601_ctrl;
  import ft601_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ft601_ctrl_if bus();

`ifdef FT601_CTRL_STATS_EN
  logic [31:0] rx_words;
  logic [31:0] tx_words;
`endif

  ft601_ctrl #(.MAX_BURST(64), .SKID_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FT601_CTRL_STATS_EN
    ,
    .rx_words(rx_words),
    .tx_words(tx_words)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [35:0] chip_rxq[$];
  logic [35:0] rx_sb[$];
  logic [35:0] txq[$];
  logic [35:0] tx_sb[$];
  int burst_dir[$];
  int burst_len[$];

  int cur_rd, cur_wr, oe_run, oe_runs, oe_bad, ovl_bad, gap_bad, wr_bad, trdy_bad;
  int rx_got, tx_got, cyc, txe_base, prev_dir, cur_dir;
  bit rnd_ready, txe_pulse;
  logic prev_rd_n, prev_bus_oe;

  int exp2[4] = '{64, 64, 64, 8};
  int exp5[8] = '{64, 64, 64, 64, 64, 64, 8, 8};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    burst_dir.delete();
    burst_len.delete();
    oe_runs = 0;
    rx_got  = 0;
    tx_got  = 0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (k < 3000 && (rx_sb.size() != 0 || tx_sb.size() != 0 || chip_rxq.size() != 0)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 64'(k < 3000), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  // Chip and stream environment: drive at negedge, evaluate the coming edge after settling.
  initial begin
    bus.rxf_n = 1'b1; bus.txe_n = 1'b0; bus.data_in = '0; bus.be_in = '0;
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.tx_be = '0; bus.rx_ready = 1'b1;
    cyc = 0; cur_rd = 0; cur_wr = 0; oe_run = 0; oe_runs = 0; oe_bad = 0;
    ovl_bad = 0; gap_bad = 0; wr_bad = 0; trdy_bad = 0; rx_got = 0; tx_got = 0;
    prev_rd_n = 1'b1; prev_bus_oe = 1'b0; prev_dir = 0;
    forever begin
      @(negedge clk);
      bus.rxf_n = (chip_rxq.size() == 0);
      if (chip_rxq.size() != 0) {bus.be_in, bus.data_in} = chip_rxq[0];
      else {bus.be_in, bus.data_in} = 36'd0;
      bus.tx_valid = (txq.size() != 0);
      if (txq.size() != 0) {bus.tx_be, bus.tx_data} = txq[0];
      else {bus.tx_be, bus.tx_data} = 36'd0;
      bus.txe_n = (txe_pulse && (cyc - txe_base >= 3) && (cyc - txe_base <= 5)) ? 1'b1 : 1'b0;
      bus.rx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (reset_n) begin
        if (!bus.rd_n && !bus.rxf_n) begin
          void'(chip_rxq.pop_front());
          cur_rd++;
        end
        if (!bus.wr_n) begin
          tx_got++;
          cur_wr++;
          chk("tx_sb_nonempty", 64'(tx_sb.size() != 0), 64'd1);
          if (tx_sb.size() != 0) chk("tx_word", 64'({bus.be_out, bus.data_out}), 64'(tx_sb.pop_front()));
          if (txq.size() != 0) void'(txq.pop_front());
        end
        if (bus.rx_valid && bus.rx_ready) begin
          rx_got++;
          chk("rx_sb_nonempty", 64'(rx_sb.size() != 0), 64'd1);
          if (rx_sb.size() != 0) chk("rx_word", 64'({bus.rx_be, bus.rx_data}), 64'(rx_sb.pop_front()));
        end
        if (!bus.wr_n && (bus.txe_n || !bus.tx_valid)) wr_bad++;
        if (bus.tx_ready !== !bus.wr_n) trdy_bad++;
        if (bus.tx_ready && !bus.bus_oe) trdy_bad++;
        if (prev_rd_n == 1'b0 && bus.rd_n == 1'b1) begin
          burst_dir.push_back(1); burst_len.push_back(cur_rd); cur_rd = 0;
        end
        if (prev_bus_oe == 1'b1 && bus.bus_oe == 1'b0) begin
          burst_dir.push_back(2); burst_len.push_back(cur_wr); cur_wr = 0;
        end
        if (!bus.oe_n && bus.rd_n) oe_run++;
        else if (oe_run != 0) begin
          oe_runs++;
          if (oe_run != 1) oe_bad++;
          oe_run = 0;
        end
        cur_dir = bus.bus_oe ? 2 : (!bus.oe_n ? 1 : 0);
        if (bus.bus_oe && !bus.oe_n) ovl_bad++;
        if (prev_dir != 0 && cur_dir != 0 && cur_dir != prev_dir) gap_bad++;
        prev_dir = cur_dir;
        prev_rd_n = bus.rd_n;
        prev_bus_oe = bus.bus_oe;
      end else begin
        cur_rd = 0; cur_wr = 0; oe_run = 0; prev_dir = 0;
        prev_rd_n = 1'b1; prev_bus_oe = 1'b0;
      end
      cyc++;
    end
  end

  // Directed test sequence.
  initial begin
    int k;
    int sum;
    reset_n = 1'b0; rnd_ready = 1'b0; txe_pulse = 1'b0; txe_base = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe_n", 64'(bus.oe_n), 64'd1);
    chk("rst_rd_n", 64'(bus.rd_n), 64'd1);
    chk("rst_wr_n", 64'(bus.wr_n), 64'd1);
    chk("rst_bus_oe", 64'(bus.bus_oe), 64'd0);
    chk("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
    chk("rst_tx_ready", 64'(bus.tx_ready), 64'd0);
    chk("rst_siwu_n", 64'(bus.siwu_n), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // 16 preloaded words, single burst.
    for (int i = 0; i < 16; i++) begin
      chip_rxq.push_back({4'hF, 32'(i)});
      rx_sb.push_back({4'hF, 32'(i)});
    end
    wait_done("t1");
    chk("t1_nbursts", 64'(burst_dir.size()), 64'd1);
    if (burst_dir.size() >= 1) begin
      chk("t1_dir", 64'(burst_dir[0]), 64'd1);
      chk("t1_len", 64'(burst_len[0]), 64'd16);
    end
    chk("t1_rdoe_runs", 64'(oe_runs), 64'd1);
    chk("t1_rx_got", 64'(rx_got), 64'd16);
    chk("t1_idle_oe_n", 64'(bus.oe_n), 64'd1);
    chk("t1_idle_bus_oe", 64'(bus.bus_oe), 64'd0);
`ifdef FT601_CTRL_STATS_EN
    chk("t1_rx_words", 64'(rx_words), 64'd16);
`endif
    clear_mon();

    // 200 words split into MAX_BURST bursts.
    for (int i = 0; i < 200; i++) begin
      chip_rxq.push_back({4'(i), 32'hA000_0000 + 32'(i)});
      rx_sb.push_back({4'(i), 32'hA000_0000 + 32'(i)});
    end
    wait_done("t2");
    chk("t2_nbursts", 64'(burst_len.size()), 64'd4);
    for (int i = 0; i < burst_len.size() && i < 4; i++) chk("t2_len", 64'(burst_len[i]), 64'(exp2[i]));
    chk("t2_rdoe_runs", 64'(oe_runs), 64'd4);
    chk("t2_rx_got", 64'(rx_got), 64'd200);
    clear_mon();

    // 100 words with a randomly stalling consumer.
    rnd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chip_rxq.push_back({4'(~i), 32'h5500_0000 ^ 32'(i * 7)});
      rx_sb.push_back({4'(~i), 32'h5500_0000 ^ 32'(i * 7)});
    end
    wait_done("t3");
    rnd_ready = 1'b0;
    sum = 0;
    foreach (burst_len[i]) sum += burst_len[i];
    chk("t3_captured", 64'(sum), 64'd100);
    chk("t3_rx_got", 64'(rx_got), 64'd100);
    clear_mon();

    // 10 tx words with txe_n high for cycles 3..5.
    txe_base = cyc;
    txe_pulse = 1'b1;
    for (int i = 0; i < 10; i++) begin
      txq.push_back({4'(i + 3), 32'hC0DE_0000 + 32'(i)});
      tx_sb.push_back({4'(i + 3), 32'hC0DE_0000 + 32'(i)});
    end
    wait_done("t4");
    txe_pulse = 1'b0;
    chk("t4_tx_got", 64'(tx_got), 64'd10);
    chk("t4_wr_gated", 64'(wr_bad), 64'd0);
`ifdef FT601_CTRL_STATS_EN
    chk("t4_tx_words", 64'(tx_words), 64'd10);
`endif
    clear_mon();

    // Continuous rx and tx demand after reset: alternating bursts starting with RD.
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      chip_rxq.push_back({4'hA, 32'h1000_0000 + 32'(i)});
      rx_sb.push_back({4'hA, 32'h1000_0000 + 32'(i)});
      txq.push_back({4'h5, 32'h2000_0000 + 32'(i)});
      tx_sb.push_back({4'h5, 32'h2000_0000 + 32'(i)});
    end
    wait_done("t5");
    chk("t5_nbursts", 64'(burst_dir.size()), 64'd8);
    for (int i = 0; i < burst_dir.size() && i < 8; i++) begin
      chk("t5_dir", 64'(burst_dir[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t5_len", 64'(burst_len[i]), 64'(exp5[i]));
    end
    chk("t5_rx_got", 64'(rx_got), 64'd200);
    chk("t5_tx_got", 64'(tx_got), 64'd200);
    chk("t5_overlap", 64'(ovl_bad), 64'd0);
    chk("t5_gap", 64'(gap_bad), 64'd0);
    clear_mon();

    // Reset in the middle of a read burst.
    for (int i = 0; i < 50; i++) begin
      chip_rxq.push_back({4'h3, 32'h3000_0000 + 32'(i)});
      rx_sb.push_back({4'h3, 32'h3000_0000 + 32'(i)});
    end
    k = 0;
    while (k < 200 && bus.rd_n) begin
      @(negedge clk);
      k++;
    end
    chk("t6_rd_start", 64'(k < 200), 64'd1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_oe_n", 64'(bus.oe_n), 64'd1);
    chk("t6_rd_n", 64'(bus.rd_n), 64'd1);
    chk("t6_wr_n", 64'(bus.wr_n), 64'd1);
    chk("t6_bus_oe", 64'(bus.bus_oe), 64'd0);
    chk("t6_rx_valid", 64'(bus.rx_valid), 64'd0);
    chk("t6_tx_ready", 64'(bus.tx_ready), 64'd0);
`ifdef FT601_CTRL_STATS_EN
    chk("t6_rx_words", 64'(rx_words), 64'd0);
    chk("t6_tx_words", 64'(tx_words), 64'd0);
`endif
    @(negedge clk);
    chip_rxq.delete();
    rx_sb.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();

    // Fresh words after reset must arrive without stale skid entries ahead of them.
    for (int i = 0; i < 4; i++) begin
      chip_rxq.push_back({4'hC, 32'h4000_0000 + 32'(i)});
      rx_sb.push_back({4'hC, 32'h4000_0000 + 32'(i)});
    end
    wait_done("t7");
    chk("t7_rx_got", 64'(rx_got), 64'd4);

    chk("rdoe_one_cycle", 64'(oe_bad), 64'd0);
    chk("tx_ready_rule", 64'(trdy_bad), 64'd0);
    chk("wr_n_rule", 64'(wr_bad), 64'd0);
    chk("dir_overlap", 64'(ovl_bad), 64'd0);
    chk("dir_gap", 64'(gap_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
